// File: rtl/mask_generation_vga.sv
// Row mask generator for a 640x480 VGA pipeline.
// Produces one row mask per enabled clock in one of four modes: rotate right,
// rotate left, 32-bit LFSR fill, or a repeated short pattern. The slide and
// random modes are seeded by a 32-bit word shifted in serially. The repeated
// mode is driven directly by an 8-bit parallel pattern.

module mask_generation_vga #(
    parameter int ROW_W  = 640,
    parameter int SEED_W = 32,
    parameter int REP_W  = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clk_en,
    input  logic [4:0]         pattern_w,
    input  logic               pattern,
    input  logic [REP_W-1:0]   repeatedPattern,
    input  logic               load_pattern,
    input  logic [1:0]         mask_type,
    output logic [0:ROW_W-1]   mg_mask,
    output logic               rp_valid
);

    localparam int         N_WORDS  = ROW_W / SEED_W;
    localparam logic [5:0] CNT_LAST = 6'(SEED_W - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_t;

    state_t              state, state_nx;
    logic [0:SEED_W-1]   seed, seed_nx, seed_shift;
    logic [5:0]          cnt, cnt_nx;
    logic [SEED_W-1:0]   lfsr, lfsr_nx, rnd_last;
    logic [0:ROW_W-1]    mask_nx, rep_mask, rnd_mask;
    logic                valid_nx;
    logic [3:0]          rep_len;

    // Each serial bit enters at seed[0], so the first bit ends up at seed[31].
    assign seed_shift = {pattern, seed[0:SEED_W-2]};

    // An out-of-range period falls back to the full pattern width.
    assign rep_len = (pattern_w == 5'd0 || pattern_w > 5'd8) ? 4'd8 : pattern_w[3:0];

    // Repeated fill: index i takes pattern bit 7 - (i mod L); a wrapping phase
    // counter avoids a real modulo.
    always_comb begin
        logic [2:0] ph;
        ph       = 3'd0;
        rep_mask = '0;
        for (int i = 0; i < ROW_W; i++) begin
            rep_mask[i] = repeatedPattern[3'd7 - ph];
            if ({1'b0, ph} == rep_len - 4'd1)
                ph = 3'd0;
            else
                ph = ph + 3'd1;
        end
    end

    // Random fill: 20 unrolled LFSR steps; word k is the state after step k+1,
    // its MSB landing on the leftmost pixel of that word.
    always_comb begin
        logic [SEED_W-1:0] s;
        s        = lfsr;
        rnd_mask = '0;
        for (int k = 0; k < N_WORDS; k++) begin
            s = {s[SEED_W-2:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
            rnd_mask[k*SEED_W +: SEED_W] = s;
        end
        rnd_last = s;
    end

    // Next-state, next-mask and next-valid selection; everything holds by default.
    always_comb begin
        state_nx = state;
        seed_nx  = seed;
        cnt_nx   = cnt;
        lfsr_nx  = lfsr;
        mask_nx  = mg_mask;
        valid_nx = 1'b0;

        if (load_pattern) begin
            if (mask_type == 2'b11) begin
                mask_nx  = rep_mask;
                valid_nx = 1'b1;
                state_nx = IDLE;
                cnt_nx   = '0;
            end else begin
                seed_nx = seed_shift;
                if (state == LOAD && cnt == CNT_LAST) begin
                    mask_nx  = {seed_shift, {(ROW_W - SEED_W){1'b0}}};
                    state_nx = RUN;
                    cnt_nx   = '0;
                    // The LFSR reads the seed with seed[0] as its MSB.
                    lfsr_nx  = (seed_shift == '0) ? '1 : seed_shift;
                end else if (state == LOAD) begin
                    cnt_nx = cnt + 6'd1;
                end else begin
                    // A strobe outside LOAD starts a fresh load with this bit.
                    state_nx = LOAD;
                    cnt_nx   = 6'd1;
                end
            end
        end else if (state == RUN) begin
            case (mask_type)
                2'b00: begin
                    mask_nx  = {mg_mask[ROW_W-1], mg_mask[0:ROW_W-2]};
                    valid_nx = 1'b1;
                end
                2'b01: begin
                    mask_nx  = {mg_mask[1:ROW_W-1], mg_mask[0]};
                    valid_nx = 1'b1;
                end
                2'b10: begin
                    mask_nx  = rnd_mask;
                    lfsr_nx  = rnd_last;
                    valid_nx = 1'b1;
                end
                default: begin
                    // Repeated mode only produces a row on a strobe.
                    state_nx = IDLE;
                end
            endcase
        end
    end

    // State and output registers, all gated by the clock enable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            seed     <= '0;
            cnt      <= '0;
            lfsr     <= '0;
            mg_mask  <= '0;
            rp_valid <= 1'b0;
        end else if (clk_en) begin
            state    <= state_nx;
            seed     <= seed_nx;
            cnt      <= cnt_nx;
            lfsr     <= lfsr_nx;
            mg_mask  <= mask_nx;
            rp_valid <= valid_nx;
        end
    end

endmodule

// File: tb/tb_mask_generation_vga.sv
// Directed testbench for mask_generation_vga with hand-computed expectations.

module tb_mask_generation_vga;

    logic         clk = 1'b0;
    logic         rst;
    logic         clk_en;
    logic [4:0]   pattern_w;
    logic         pattern;
    logic [7:0]   repeatedPattern;
    logic         load_pattern;
    logic [1:0]   mask_type;
    logic [0:639] mg_mask;
    logic         rp_valid;

    int total = 0;
    int bad   = 0;

    mask_generation_vga dut (
        .clk             (clk),
        .rst             (rst),
        .clk_en          (clk_en),
        .pattern_w       (pattern_w),
        .pattern         (pattern),
        .repeatedPattern (repeatedPattern),
        .load_pattern    (load_pattern),
        .mask_type       (mask_type),
        .mg_mask         (mg_mask),
        .rp_valid        (rp_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [639:0] got, input logic [639:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Shift in a seed so that seed[31] goes first and seed[0] last.
    task automatic load_seed(input logic [31:0] val);
        logic [0:31] sv;
        sv = val;
        for (int j = 31; j >= 0; j--) begin
            load_pattern = 1'b1;
            pattern      = sv[j];
            tick();
        end
        load_pattern = 1'b0;
        pattern      = 1'b0;
    endtask

    logic [0:639] img, exp_v;
    int           nval;

    initial begin
        rst = 1'b1; clk_en = 1'b1; pattern_w = 5'd0; pattern = 1'b0;
        repeatedPattern = 8'h00; load_pattern = 1'b0; mask_type = 2'b00;
        #12;
        check("reset_mask", mg_mask, '0);
        check("reset_valid", 640'(rp_valid), 640'(0));
        rst = 1'b0;
        tick();
        tick();
        check("idle_valid", 640'(rp_valid), 640'(0));

        // Slide right
        img = {32'h80000001, 608'b0};
        mask_type = 2'b00;
        load_seed(32'h80000001);
        check("sr_loaded_img", mg_mask, img);
        check("sr_loaded_valid", 640'(rp_valid), 640'(0));
        tick();
        exp_v = '0; exp_v[1] = 1'b1; exp_v[32] = 1'b1;
        check("sr_row1", mg_mask, exp_v);
        check("sr_row1_valid", 640'(rp_valid), 640'(1));
        nval = 1;
        for (int r = 2; r <= 640; r++) begin
            tick();
            if (rp_valid) nval++;
        end
        check("sr_row640", mg_mask, img);
        check("sr_valid_cnt", 640'(nval), 640'(640));

        // Clock-enable freeze mid slide
        tick();
        exp_v = '0; exp_v[1] = 1'b1; exp_v[32] = 1'b1;
        check("ce_row641", mg_mask, exp_v);
        clk_en = 1'b0;
        for (int c = 0; c < 5; c++) tick();
        check("ce_frozen_mask", mg_mask, exp_v);
        check("ce_frozen_valid", 640'(rp_valid), 640'(1));
        clk_en = 1'b1;
        tick();
        exp_v = '0; exp_v[2] = 1'b1; exp_v[33] = 1'b1;
        check("ce_resume", mg_mask, exp_v);
        check("ce_resume_valid", 640'(rp_valid), 640'(1));

        // Slide left, reload from RUN
        mask_type = 2'b01;
        load_seed(32'h80000001);
        check("sl_loaded_img", mg_mask, img);
        check("sl_loaded_valid", 640'(rp_valid), 640'(0));
        tick();
        exp_v = '0; exp_v[639] = 1'b1; exp_v[30] = 1'b1;
        check("sl_row1", mg_mask, exp_v);
        nval = 1;
        for (int r = 2; r <= 640; r++) begin
            tick();
            if (rp_valid) nval++;
        end
        check("sl_row640", mg_mask, img);
        check("sl_valid_cnt", 640'(nval), 640'(640));

        // Random
        mask_type = 2'b10;
        load_seed(32'h00000001);
        check("rnd_loaded_valid", 640'(rp_valid), 640'(0));
        tick();
        check("rnd_word0", 640'(mg_mask[0:31]), 640'(32'h00000003));
        check("rnd_word1", 640'(mg_mask[32:63]), 640'(32'h00000006));
        check("rnd_word2", 640'(mg_mask[64:95]), 640'(32'h0000000D));
        nval = rp_valid ? 1 : 0;
        for (int r = 2; r <= 481; r++) begin
            tick();
            if (rp_valid) nval++;
        end
        check("rnd_481_rows", 640'(nval), 640'(481));

        // Asynchronous reset mid-run
        #2;
        rst = 1'b1;
        #1;
        check("rst_mid_mask", mg_mask, '0);
        check("rst_mid_valid", 640'(rp_valid), 640'(0));
        @(negedge clk);
        rst = 1'b0;
        nval = 0;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (rp_valid) nval++;
        end
        check("rst_after_valid", 640'(nval), 640'(0));

        // Repeated: period 4
        mask_type = 2'b11; pattern_w = 5'd4; repeatedPattern = 8'hA0;
        load_pattern = 1'b1;
        tick();
        load_pattern = 1'b0;
        check("rep4_mask", mg_mask, {160{4'hA}});
        check("rep4_valid", 640'(rp_valid), 640'(1));
        tick();
        check("rep4_valid_drop", 640'(rp_valid), 640'(0));
        check("rep4_hold", mg_mask, {160{4'hA}});

        // Repeated: period 3
        pattern_w = 5'd3; repeatedPattern = 8'b110_00000;
        load_pattern = 1'b1;
        tick();
        load_pattern = 1'b0;
        check("rep3_mask", mg_mask, {{213{3'b110}}, 1'b1});
        check("rep3_valid", 640'(rp_valid), 640'(1));
        tick();
        check("rep3_valid_drop", 640'(rp_valid), 640'(0));

        // Repeated: out-of-range periods fall back to 8
        pattern_w = 5'd0; repeatedPattern = 8'hC3;
        load_pattern = 1'b1;
        tick();
        load_pattern = 1'b0;
        check("rep0_mask", mg_mask, {80{8'hC3}});
        pattern_w = 5'd9; repeatedPattern = 8'h5E;
        load_pattern = 1'b1;
        tick();
        load_pattern = 1'b0;
        check("rep9_mask", mg_mask, {80{8'h5E}});
        tick();
        check("rep9_valid_drop", 640'(rp_valid), 640'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
